// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// Module  : alu_sequencer_pkg
// Brief   : Opcodes, ALU select codes, CCR bit positions, branch condition
//           codes and FSM state type shared by the ALU sequencer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu_sequencer_pkg;

  // Command opcodes (4 bits)
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_INCA = 4'h4;
  localparam logic [3:0] OP_INCB = 4'h5;
  localparam logic [3:0] OP_DECA = 4'h6;
  localparam logic [3:0] OP_DECB = 4'h7;
  localparam logic [3:0] OP_LDA  = 4'h8;
  localparam logic [3:0] OP_LDB  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;

  // ALU select codes (3 bits)
  localparam logic [2:0] SEL_ADD  = 3'd0;
  localparam logic [2:0] SEL_SUB  = 3'd1;
  localparam logic [2:0] SEL_NONE = 3'd0;

  // CCR bit positions {N,Z,V,C}
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  // Branch condition select codes
  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_EQ = 4'h1;
  localparam logic [3:0] COND_NE = 4'h2;
  localparam logic [3:0] COND_MI = 4'h3;
  localparam logic [3:0] COND_PL = 4'h4;
  localparam logic [3:0] COND_VS = 4'h5;
  localparam logic [3:0] COND_VC = 4'h6;
  localparam logic [3:0] COND_CS = 4'h7;
  localparam logic [3:0] COND_CC = 4'h8;
  localparam logic [3:0] COND_GE = 4'h9;
  localparam logic [3:0] COND_LT = 4'hA;
  localparam logic [3:0] COND_GT = 4'hB;
  localparam logic [3:0] COND_LE = 4'hC;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // ALU select driven for a given opcode; non-ALU opcodes park the ALU on 000
  function automatic logic [2:0] sel_for_op(input logic [3:0] op);
    logic [2:0] sel;
    if (op[3] == 1'b0) begin
      sel = op[2:0];
    end else if (op == OP_CMP) begin
      sel = SEL_SUB;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_cond_eval.sv
// ---------------------------------------------------------------------------
// Module  : alu_sequencer_cond_eval
// Brief   : Combinational branch-condition evaluator over the CCR.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_sequencer_cond_eval
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] i_ccr,
  input  logic [3:0] i_cond_sel,
  output logic       o_cond_true
);

  logic w_n;
  logic w_z;
  logic w_v;
  logic w_c;

  assign w_n = i_ccr[CCR_N];
  assign w_z = i_ccr[CCR_Z];
  assign w_v = i_ccr[CCR_V];
  assign w_c = i_ccr[CCR_C];

  // Decode the selected condition; unused select codes evaluate false
  always_comb begin
    o_cond_true = 1'b0;
    case (i_cond_sel)
      COND_AL: o_cond_true = 1'b1;
      COND_EQ: o_cond_true = w_z;
      COND_NE: o_cond_true = ~w_z;
      COND_MI: o_cond_true = w_n;
      COND_PL: o_cond_true = ~w_n;
      COND_VS: o_cond_true = w_v;
      COND_VC: o_cond_true = ~w_v;
      COND_CS: o_cond_true = w_c;
      COND_CC: o_cond_true = ~w_c;
      COND_GE: o_cond_true = (w_n == w_v);
      COND_LT: o_cond_true = (w_n != w_v);
      COND_GT: o_cond_true = ~w_z & (w_n == w_v);
      COND_LE: o_cond_true = w_z | (w_n != w_v);
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// Module  : alu_sequencer
// Brief   : Initiator side of the 8-bit ALU interface. Accepts commands on a
//           valid/ready port, drives A/B/SEL into the ALU, writes RESULT back
//           into accumulator A or B and NZVC into the CCR. Fixed two-cycle
//           accept-to-done latency.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [3:0] i_cmd_op,
  input  logic [7:0] i_cmd_imm,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [2:0] o_alu_sel,
  input  logic [7:0] i_alu_result,
  input  logic [3:0] i_alu_nzvc,
  output logic [7:0] o_reg_a,
  output logic [7:0] o_reg_b,
  output logic [3:0] o_ccr,
  output logic       o_done,
  output logic       o_err,
  input  logic [3:0] i_cond_sel,
  output logic       o_cond_true
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [3:0] r_op;
  logic [7:0] r_imm;
  logic [2:0] r_sel;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_ccr;

  logic       w_accept;
  logic       w_capture;
  logic       w_illegal;

  // Opcodes above CMP have no defined behaviour
  assign w_illegal = (r_op > OP_CMP);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/strobe decode
  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        o_err       = w_illegal;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch on accept; result/flag writeback at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 4'h0;
      r_imm <= 8'h00;
      r_sel <= 3'd0;
      r_a   <= 8'h00;
      r_b   <= 8'h00;
      r_ccr <= 4'h0;
    end else begin
      if (w_accept) begin
        r_op  <= i_cmd_op;
        r_imm <= i_cmd_imm;
        r_sel <= sel_for_op(i_cmd_op);
      end
      if (w_capture) begin
        case (r_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INCA, OP_DECA: begin
            r_a   <= i_alu_result;
            r_ccr <= i_alu_nzvc;
          end
          OP_INCB, OP_DECB: begin
            r_b   <= i_alu_result;
            r_ccr <= i_alu_nzvc;
          end
          OP_LDA: r_a <= r_imm;
          OP_LDB: r_b <= r_imm;
          OP_CMP: r_ccr <= i_alu_nzvc;
          default: begin
            // illegal opcode: architectural state is left untouched
          end
        endcase
      end
    end
  end

  assign o_alu_a   = r_a;
  assign o_alu_b   = r_b;
  assign o_alu_sel = r_sel;
  assign o_reg_a   = r_a;
  assign o_reg_b   = r_b;
  assign o_ccr     = r_ccr;

  alu_sequencer_cond_eval u_cond_eval (
    .i_ccr       (r_ccr),
    .i_cond_sel  (i_cond_sel),
    .o_cond_true (o_cond_true)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// Module  : tb_alu_sequencer
// Brief   : Self-checking bench for alu_sequencer with a behavioural ALU and a
//           transaction-level reference model of the sequencer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'h0;
  logic [7:0] cmd_imm = 8'h00;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic [3:0] alu_nzvc;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [3:0] ccr;
  logic       done;
  logic       err;
  logic [3:0] cond_sel = 4'h0;
  logic       cond_true;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_imm    (cmd_imm),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_sel    (alu_sel),
    .i_alu_result (alu_result),
    .i_alu_nzvc   (alu_nzvc),
    .o_reg_a      (reg_a),
    .o_reg_b      (reg_b),
    .o_ccr        (ccr),
    .o_done       (done),
    .o_err        (err),
    .i_cond_sel   (cond_sel),
    .o_cond_true  (cond_true)
  );

  // Behavioural 8-bit ALU: returns {N,Z,V,C,result}; C is carry for add/inc, borrow for sub/dec
  function automatic logic [11:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic v;
    logic c;
    w = 9'd0; r = 8'd0; v = 1'b0; c = 1'b0;
    case (s)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = a + 8'd1; c = (a == 8'hFF); v = (a == 8'h7F); end
      3'd5: begin r = b + 8'd1; c = (b == 8'hFF); v = (b == 8'h7F); end
      3'd6: begin r = a - 8'd1; c = (a == 8'h00); v = (a == 8'h80); end
      default: begin r = b - 8'd1; c = (b == 8'h00); v = (b == 8'h80); end
    endcase
    return {r[7], (r == 8'h00), v, c, r};
  endfunction

  assign {alu_nzvc, alu_result} = alu_f(alu_sel, alu_a, alu_b);

  // Branch condition table, written directly from the condition list
  function automatic logic exp_cond(input logic [3:0] f, input logic [3:0] s);
    logic n, z, v, c;
    {n, z, v, c} = f;
    case (s)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return n;
      4'd4:  return !n;
      4'd5:  return v;
      4'd6:  return !v;
      4'd7:  return c;
      4'd8:  return !c;
      4'd9:  return n == v;
      4'd10: return n != v;
      4'd11: return !z && (n == v);
      4'd12: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: commands are retired as transactions; "left" counts cycles to go
  logic [7:0] ma, mb, pa, pb;
  logic [3:0] mccr, pccr;
  logic [2:0] msel;
  logic       perr, m_acc;
  int         left;

  always @(posedge clk or negedge rst_n) begin
    logic [11:0] f;
    if (!rst_n) begin
      ma = 0; mb = 0; mccr = 0; msel = 0; left = 0; m_acc = 0; perr = 0;
      pa = 0; pb = 0; pccr = 0;
    end else begin
      m_acc = 0;
      if (left == 2) begin
        ma = pa; mb = pb; mccr = pccr; left = 1;
      end else if (left == 1) begin
        left = 0;
      end else if (cmd_valid) begin
        pa = ma; pb = mb; pccr = mccr; perr = 0;
        if (cmd_op < 4'd8) begin
          msel = cmd_op[2:0];
          f = alu_f(msel, ma, mb);
          if (cmd_op == 4'd5 || cmd_op == 4'd7) pb = f[7:0];
          else pa = f[7:0];
          pccr = f[11:8];
        end else if (cmd_op == 4'd8) begin
          msel = 0; pa = cmd_imm;
        end else if (cmd_op == 4'd9) begin
          msel = 0; pb = cmd_imm;
        end else if (cmd_op == 4'd10) begin
          msel = 3'd1;
          f = alu_f(msel, ma, mb);
          pccr = f[11:8];
        end else begin
          msel = 0; perr = 1;
        end
        left = 2;
        m_acc = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, plus a log of retirements for literal checks
  int         done_cnt = 0;
  int         err_cnt  = 0;
  logic [7:0] q_a[$];
  logic [3:0] q_ccr[$];
  int         q_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", cmd_ready, left == 0);
      chk("done", done, left == 1);
      chk("err", err, (left == 1) && perr);
      chk("reg_a", reg_a, ma);
      chk("reg_b", reg_b, mb);
      chk("ccr", ccr, mccr);
      chk("alu_a", alu_a, ma);
      chk("alu_b", alu_b, mb);
      chk("alu_sel", alu_sel, msel);
      chk("cond_true", cond_true, exp_cond(mccr, cond_sel));
    end
    if (done) begin
      done_cnt++;
      q_a.push_back(reg_a);
      q_ccr.push_back(ccr);
      q_cyc.push_back(cyc);
    end
    if (err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Present a command until the model takes it; leaves us 2 units after the accept edge
  task automatic send(input logic [3:0] op, input logic [7:0] imm);
    bit got;
    got = 0;
    cmd_valid = 1; cmd_op = op; cmd_imm = imm;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = m_acc;
    end
    if (!got) chk("accept_timeout", 0, 1);
    #1 cmd_valid = 0;
  endtask

  // Full command: send, confirm done arrives on the second cycle after accept, return idle
  task automatic run(input logic [3:0] op, input logic [7:0] imm);
    send(op, imm);
    @(posedge clk); #1;
    chk("done_latency", done, 1);
    #1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    // Reset and reset values
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst_reg_a", reg_a, 8'h00);
    chk("rst_ccr", ccr, 4'h0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_alu_sel", alu_sel, 3'd0);

    // 1. Reset during EXEC aborts the LDA
    done_cnt = 0;
    send(4'h8, 8'h55);
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    chk("t1_no_done", done_cnt, 0);
    chk("t1_reg_a", reg_a, 8'h00);
    chk("t1_ready", cmd_ready, 1);

    // 2. 7F + 01 overflows into the sign bit
    run(4'h8, 8'h7F);
    run(4'h9, 8'h01);
    run(4'h0, 8'h00);
    chk("t2_reg_a", reg_a, 8'h80);
    chk("t2_ccr", ccr, 4'b1010);

    // 3. Compare equal values
    run(4'h8, 8'h05);
    run(4'h9, 8'h05);
    run(4'hA, 8'h00);
    chk("t3_reg_a", reg_a, 8'h05);
    chk("t3_ccr", ccr, 4'b0100);
    cond_sel = 4'd1; #1;
    chk("t3_eq", cond_true, 1);
    cond_sel = 4'd2; #1;
    chk("t3_ne", cond_true, 0);

    // 4. DECB from zero wraps and sets N
    run(4'h9, 8'h00);
    run(4'h7, 8'h00);
    chk("t4_reg_b", reg_b, 8'hFF);
    chk("t4_reg_a", reg_a, 8'h05);
    chk("t4_n", ccr[3], 1);
    chk("t4_z", ccr[2], 0);
    cond_sel = 4'd3; #1;
    chk("t4_mi", cond_true, 1);

    // 5. Illegal opcode with valid held through busy: one accept, done+err together
    done_cnt = 0; err_cnt = 0;
    send(4'hC, 8'hAA);
    cmd_valid = 1;
    @(posedge clk);
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (4) tick();
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_reg_a", reg_a, 8'h05);
    chk("t5_reg_b", reg_b, 8'hFF);
    chk("t5_n", ccr[3], 1);

    // 6. Three back-to-back INCA from FE with valid held
    run(4'h8, 8'hFE);
    q_a.delete(); q_ccr.delete(); q_cyc.delete();
    n_acc = 0;
    cmd_valid = 1; cmd_op = 4'h4;
    for (int i = 0; i < 30 && n_acc < 3; i++) begin
      @(posedge clk); #1;
      if (m_acc) n_acc++;
    end
    cmd_valid = 0;
    repeat (4) tick();
    chk("t6_accepts", n_acc, 3);
    chk("t6_dones", q_a.size(), 3);
    if (q_a.size() == 3) begin
      chk("t6_a0", q_a[0], 8'hFF);
      chk("t6_a1", q_a[1], 8'h00);
      chk("t6_z1", q_ccr[1][2], 1);
      chk("t6_a2", q_a[2], 8'h01);
      chk("t6_gap01", q_cyc[1] - q_cyc[0], 3);
      chk("t6_gap12", q_cyc[2] - q_cyc[1], 3);
    end

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 4'($urandom_range(0, 15));
      cmd_imm   = 8'($urandom);
      cond_sel  = 4'($urandom_range(0, 15));
      tick();
    end
    cmd_valid = 0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
